xeng_acc_unloader: RTL and testbench

Receive-side companion to the X-engine tap chain. It captures the accumulated correlation words that the last baseline tap places on the accumulation shift register (`acc`/`valid` pair), tags each word with its baseline index within the integration window, and buffers it in a FIFO. It then serialises each word into one complex output per Stokes product, behind a valid/ready handshake, for the downstream packetiser.

---
 rtl/xeng_acc_unloader.sv | 205 ++++++++++++++++++++
 tb/tb_xeng_acc_unloader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xeng_acc_unloader.sv
// X-engine accumulation unloader: tags tap-chain words with a baseline index, buffers them, serialises per Stokes product.
// Build macro XENG_ACC_UNLOADER_DROP_CNT_EN adds the 16-bit saturating drop counter; otherwise drop_cnt is tied to 0.

// Generic synchronous FIFO, registered occupancy, combinational head read.
// Latency: a write is visible (empty deasserts) the cycle after it is accepted.
// Backpressure: write is refused when full unless a read happens in the same cycle.
module xeng_acc_unloader_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty
);
  localparam int DEPTH = 1 << DEPTH_BITS;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic [DEPTH_BITS:0]   count;
  logic                  do_wr;
  logic                  do_rd;

  assign empty  = (count == '0);
  assign full   = count[DEPTH_BITS];
  assign do_rd  = rd_rdy & ~empty;
  // A read frees the slot being written when full, so both proceed.
  assign do_wr  = wr_vld & (~full | do_rd);
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + DEPTH_BITS'(1);
      if (do_rd) rd_ptr <= rd_ptr + DEPTH_BITS'(1);
      count <= count + {{DEPTH_BITS{1'b0}}, do_wr} - {{DEPTH_BITS{1'b0}}, do_rd};
    end
  end
endmodule

// Captures accumulation words, tags them with baseline index, emits one complex Stokes product per beat.
// Latency: valid_in sampled at edge t -> FIFO write at t+1 -> out_valid (s=0) after edge t+2.
// Backpressure: out_ready low freezes the beat; input has none, words are dropped when the FIFO is full.
module xeng_acc_unloader #(
  parameter int BITWIDTH            = 4,
  parameter int P_FACTOR_BITS       = 2,
  parameter int SERIAL_ACC_LEN_BITS = 7,
  parameter int N_POLS              = 2,
  parameter int N_WORDS             = 544,
  parameter int BL_BITS             = 10,
  parameter int FIFO_DEPTH_BITS     = 5,
  localparam int N_STOKES  = N_POLS * N_POLS,
  localparam int FIELD_W   = 2 * BITWIDTH + 1 + P_FACTOR_BITS + SERIAL_ACC_LEN_BITS,
  localparam int ACC_WIDTH = N_STOKES * 2 * FIELD_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sync_in,
  input  logic [ACC_WIDTH-1:0] acc_in,
  input  logic                 valid_in,
  output logic [2*FIELD_W-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BL_BITS-1:0]   out_bl,
  output logic [1:0]           out_stokes,
  output logic                 out_last,
  output logic                 overflow,
  output logic [15:0]          drop_cnt
);
  localparam int SLICE_W = 2 * FIELD_W;
  localparam int ENTRY_W = BL_BITS + ACC_WIDTH;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  localparam logic [1:0]         LAST_S  = 2'(N_STOKES - 1);
  localparam logic [BL_BITS-1:0] LAST_BL = BL_BITS'(N_WORDS - 1);

  logic [ACC_WIDTH-1:0] acc_q;
  logic                 in_vld_q;
  logic                 sync_q;
  logic [BL_BITS-1:0]   bl_cnt;
  logic [BL_BITS-1:0]   wr_tag;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [ENTRY_W-1:0]   fifo_rd_dat;
  logic                 pop;
  logic                 drop;

  logic [0:0]           state;
  logic [1:0]           s_q;
  logic [ACC_WIDTH-1:0] word_q;
  logic [BL_BITS-1:0]   tag_q;
  logic                 beat_done;
  logic                 word_done;

  function automatic logic [BL_BITS-1:0] bl_inc(input logic [BL_BITS-1:0] b);
    return (b == LAST_BL) ? '0 : b + BL_BITS'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      in_vld_q <= 1'b0;
      sync_q   <= 1'b0;
    end else begin
      acc_q    <= acc_in;
      in_vld_q <= valid_in;
      sync_q   <= sync_in;
    end
  end

  // A word coinciding with sync is tagged 0, so the counter continues from 1.
  assign wr_tag = sync_q ? '0 : bl_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bl_cnt <= '0;
    end else if (in_vld_q) begin
      bl_cnt <= bl_inc(wr_tag);
    end else if (sync_q) begin
      bl_cnt <= '0;
    end
  end

  xeng_acc_unloader_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (in_vld_q),
    .wr_dat ({wr_tag, acc_q}),
    .rd_rdy (pop),
    .rd_dat (fifo_rd_dat),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign drop      = in_vld_q & fifo_full & ~pop;
  assign beat_done = (state == ST_EMIT) & out_ready;
  assign word_done = beat_done & (s_q == LAST_S);
  assign pop       = ~fifo_empty & ((state == ST_IDLE) | word_done);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      s_q    <= '0;
      word_q <= '0;
      tag_q  <= '0;
    end else if (pop) begin
      state  <= ST_EMIT;
      s_q    <= '0;
      word_q <= fifo_rd_dat[ACC_WIDTH-1:0];
      tag_q  <= fifo_rd_dat[ENTRY_W-1:ACC_WIDTH];
    end else if (word_done) begin
      state <= ST_IDLE;
    end else if (beat_done) begin
      s_q <= s_q + 2'd1;
    end
  end

  assign out_valid  = (state == ST_EMIT);
  assign out_data   = word_q[int'(s_q) * SLICE_W +: SLICE_W];
  assign out_bl     = tag_q;
  assign out_stokes = s_q;
  assign out_last   = out_valid & (s_q == LAST_S) & (tag_q == LAST_BL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

`ifdef XENG_ACC_UNLOADER_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_xeng_acc_unloader.sv
// Directed bench for xeng_acc_unloader: scoreboard of expected Stokes beats checked by an output monitor.
module tb_xeng_acc_unloader;
  localparam int SW = 36;
  localparam int AW = 144;
  localparam int NW = 544;

`ifdef XENG_ACC_UNLOADER_DROP_CNT_EN
  localparam logic [15:0] EXP_DROP = 16'd8;
`else
  localparam logic [15:0] EXP_DROP = 16'd0;
`endif

  typedef struct packed {
    logic [9:0]    bl;
    logic [1:0]    st;
    logic          last;
    logic [SW-1:0] dat;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sync_in = 1'b0;
  logic          valid_in = 1'b0;
  logic          out_ready = 1'b1;
  logic [AW-1:0] acc_in = '0;
  logic [SW-1:0] out_data;
  logic          out_valid;
  logic [9:0]    out_bl;
  logic [1:0]    out_stokes;
  logic          out_last;
  logic          overflow;
  logic [15:0]   drop_cnt;

  beat_t sb[$];
  int    n_chk = 0;
  int    n_pass = 0;
  int    n_fail = 0;
  int    n_last = 0;

  xeng_acc_unloader dut (
    .clk        (clk),
    .rst        (rst),
    .sync_in    (sync_in),
    .acc_in     (acc_in),
    .valid_in   (valid_in),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_bl     (out_bl),
    .out_stokes (out_stokes),
    .out_last   (out_last),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1000000, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] rnd_word();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[AW-1:0];
  endfunction

  function automatic logic [AW-1:0] pat_word();
    logic [AW-1:0] w;
    for (int k = 0; k < 4; k++) w[k*SW +: SW] = {18'(k), 18'(k)};
    return w;
  endfunction

  task automatic push_word(input logic [AW-1:0] w, input int tag);
    beat_t b;
    for (int s = 0; s < 4; s++) begin
      b.bl   = 10'(tag);
      b.st   = 2'(s);
      b.last = (s == 3) && (tag == NW - 1);
      b.dat  = w[s*SW +: SW];
      sb.push_back(b);
    end
  endtask

  // Called at posedge+2; returns at the following posedge+2.
  task automatic send(input logic [AW-1:0] w, input logic sync, input int tag, input bit push);
    acc_in   = w;
    sync_in  = sync;
    valid_in = 1'b1;
    if (push) push_word(w, tag);
    @(posedge clk);
    #2;
    valid_in = 1'b0;
    sync_in  = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0 && !out_valid) break;
      cycles(1);
    end
    chk(tag, {sb.size() == 0, out_valid}, {1'b1, 1'b0});
  endtask

  task automatic chk_latency(input string tag, input logic [9:0] bl);
    @(posedge clk);
    #1;
    chk({tag, "_t1"}, out_valid, 1'b0);
    @(posedge clk);
    #1;
    chk({tag, "_t2"}, {out_valid, out_stokes, out_bl}, {1'b1, 2'd0, bl});
    #1;
  endtask

  task automatic poll_stokes(input logic [1:0] s);
    for (int i = 0; i < 20; i++) begin
      if (out_valid && out_stokes == s) break;
      cycles(1);
    end
  endtask

  always @(negedge clk) begin
    beat_t o;
    beat_t e;
    if (!rst && out_valid && out_ready) begin
      o = '{bl: out_bl, st: out_stokes, last: out_last, dat: out_data};
      chk("beat_expected", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("beat", 64'(o), 64'(e));
      end
      if (out_last) n_last++;
    end
  end

  initial begin
    logic [AW-1:0] w;
    logic [AW-1:0] a;

    // Reset state
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, '0);
    chk("rst_bl", out_bl, '0);
    chk("rst_stokes", out_stokes, '0);
    chk("rst_last", out_last, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_drop", drop_cnt, '0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    cycles(2);

    // Single word with latency
    send(pat_word(), 1'b0, 0, 1'b1);
    chk_latency("single_lat", 10'd0);
    drain("single_drain", 50);

    // Full window of 544 words plus one wrapped word
    n_last = 0;
    sync_in = 1'b1;
    cycles(1);
    sync_in = 1'b0;
    for (int i = 0; i <= NW; i++) begin
      send(rnd_word(), 1'b0, (i == NW) ? 0 : i, 1'b1);
      cycles(3);
    end
    drain("window_drain", 100);
    chk("window_last_once", n_last, 1);

    // Back-pressure mid-word (bl continues at 1)
    w = rnd_word();
    send(w, 1'b0, 1, 1'b1);
    poll_stokes(2'd1);
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_frozen", {out_valid, out_stokes, out_bl, out_data}, {1'b1, 2'd1, 10'd1, w[SW +: SW]});
      #1;
    end
    out_ready = 1'b1;
    drain("bp_drain", 50);

    // Overflow: park one word in the output register, then 40 back-to-back valids
    out_ready = 1'b0;
    a = rnd_word();
    send(a, 1'b0, 2, 1'b1);
    cycles(3);
    sync_in = 1'b1;
    cycles(1);
    sync_in = 1'b0;
    for (int i = 0; i < 40; i++) begin
      w = rnd_word();
      acc_in = w;
      valid_in = 1'b1;
      if (i < 32) push_word(w, i);
      @(posedge clk);
      #1;
      if (i == 32) chk("ovf_before_drop", overflow, 1'b0);
      if (i == 33) chk("ovf_rise", overflow, 1'b1);
      #1;
    end
    valid_in = 1'b0;
    cycles(2);
    chk("ovf_drop_cnt", drop_cnt, EXP_DROP);
    out_ready = 1'b1;
    drain("ovf_drain", 400);
    chk("ovf_sticky", overflow, 1'b1);
    chk("ovf_drop_cnt_hold", drop_cnt, EXP_DROP);
    send(rnd_word(), 1'b0, 40, 1'b1);
    drain("ovf_next_tag", 50);

    // Advance bl_cnt to 100, then sync coincident with valid
    for (int i = 41; i < 100; i++) begin
      send(rnd_word(), 1'b0, i, 1'b1);
      cycles(3);
    end
    send(rnd_word(), 1'b1, 0, 1'b1);
    cycles(3);
    send(rnd_word(), 1'b0, 1, 1'b1);
    drain("sync_valid_drain", 100);

    // Reset in the middle of a word
    w = rnd_word();
    send(w, 1'b0, 2, 1'b1);
    poll_stokes(2'd2);
    chk("rst_mid_reach", {out_valid, out_stokes}, {1'b1, 2'd2});
    out_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rstmid_valid", out_valid, 1'b0);
    chk("rstmid_data", out_data, '0);
    chk("rstmid_bl", out_bl, '0);
    chk("rstmid_stokes", out_stokes, '0);
    chk("rstmid_last", out_last, 1'b0);
    chk("rstmid_ovf", overflow, 1'b0);
    chk("rstmid_drop", drop_cnt, '0);
    sb.delete();
    cycles(2);
    rst = 1'b0;
    out_ready = 1'b1;
    cycles(1);
    send(pat_word(), 1'b0, 0, 1'b1);
    chk_latency("rstmid_lat", 10'd0);
    drain("rstmid_drain", 50);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
